// File: rtl/ram_share_arbiter_pkg.sv
// ram_share_arbiter_pkg: FSM state encoding and index helper shared by the arbiter and its picker
package ram_share_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;
  // Wraps an index into 0..n-1; callers never pass more than 2n-1.
  function automatic int wrap_idx(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction
endpackage

// File: rtl/ram_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker
//   req_i  requester levels
//   ptr_i  highest-priority index this round
//   any_o  any request present
//   win_o  first requester set scanning ptr_i, ptr_i+1, ... mod NREQ
module rr_pick
  import ram_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic            any_o,
  output logic [PW-1:0]   win_o
);
  logic [PW-1:0] idx;
  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    any_o = |req_i;
    win_o = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'(wrap_idx(int'(ptr_i) + k, NREQ));
      win_o = req_i[idx] ? idx : win_o;
    end
  end
endmodule

// File: rtl/ram_share_arbiter.sv
// ram_share_arbiter: round-robin arbiter sharing one register bank between NREQ requesters
//   clk, reset              clock, synchronous active-high reset
//   req/we/addr/wdata       per-requester access request (packed per requester)
//   ack, rdata              one-cycle one-hot completion pulse and registered read data
//   ram_load/address/in     bank pins; ram_out is the bank's combinational read data
//   lock                    present only when ARB_LOCK_EN is defined: winner keeps priority
module ram_share_arbiter
  import ram_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 3,
  parameter int DW   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]      lock,
`endif
  output logic [NREQ-1:0]      ack,
  output logic [DW-1:0]        rdata,
  output logic                 ram_load,
  output logic [AW-1:0]        ram_address,
  output logic [DW-1:0]        ram_in,
  input  logic [DW-1:0]        ram_out
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  state_e          state_q;
  logic [PW-1:0]   ptr_q, win_q, pick_win, win_inc, ptr_d;
  logic            pick_any, we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q, rdata_q;
  logic [NREQ-1:0] ack_q;
  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .win_o (pick_win)
  );
  assign win_inc = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
`ifdef ARB_LOCK_EN
  assign ptr_d = lock[win_q] ? win_q : win_inc;
`else
  assign ptr_d = win_inc;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: if (pick_any) begin
          win_q   <= pick_win;
          we_q    <= we[pick_win];
          addr_q  <= addr[pick_win*AW +: AW];
          wdata_q <= wdata[pick_win*DW +: DW];
          state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          rdata_q <= ram_out;
          ack_q   <= NREQ'(1) << win_q;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          ptr_q   <= ptr_d;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  // Load is gated by reset directly so a reset landing mid-access never writes the bank.
  assign ram_load    = (state_q == ST_ACCESS) & we_q & ~reset;
  assign ram_address = addr_q;
  assign ram_in      = wdata_q;
  assign ack         = ack_q;
  assign rdata       = rdata_q;
endmodule

// File: tb/tb_ram_share_arbiter.sv
// tb_ram_share_arbiter: randomized self-checking bench with a bank model and round-robin reference
module tb_ram_share_arbiter;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif
  logic        clk = 1'b0, reset = 1'b1, tb_init = 1'b1;
  logic [1:0]  req = '0, we = '0, lock = '0, ack;
  logic [5:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [15:0] rdata, ram_in, ram_out;
  logic        ram_load;
  logic [2:0]  ram_address;
  logic [15:0] bank_mem [8];
  logic [15:0] init_val [8];
  logic [15:0] model_mem [8];
  int          load_count = 0;
  int          mptr = 0;
  int          n_checks = 0, n_pass = 0;
  logic [1:0]  acks [$];
  int          gcyc [$];

  ram_share_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .ack(ack), .rdata(rdata), .ram_load(ram_load), .ram_address(ram_address),
    .ram_in(ram_in), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_init) for (int k = 0; k < 8; k++) bank_mem[k] <= init_val[k];
    else if (ram_load) begin
      bank_mem[ram_address] <= ram_in;
      load_count <= load_count + 1;
    end
  end
  assign ram_out = bank_mem[ram_address];

  function automatic int exp_win(input logic [1:0] m);
    for (int k = 0; k < 2; k++) if (m[(mptr + k) % 2]) return (mptr + k) % 2;
    return -1;
  endfunction

  function automatic int next_ptr(input int w);
    return (LOCK_ON && lock[w]) ? w : (w + 1) % 2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input int i, input bit w, input logic [2:0] a, input logic [15:0] d,
                        output int lat, output int load_cyc, output logic [15:0] rd,
                        output logic [1:0] ackv);
    req[i] = 1'b1; we[i] = w; addr[i*3 +: 3] = a; wdata[i*16 +: 16] = d;
    lat = -1; load_cyc = -1; rd = '0; ackv = '0;
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      @(negedge clk);
      if (ram_load) load_cyc = c;
      if (ack != 2'b00) begin lat = c; rd = rdata; ackv = ack; end
      step();
    end
    req[i] = 1'b0; we[i] = 1'b0;
    if (lat > 0) mptr = next_ptr(i);
  endtask

  task automatic run_grants(input logic [1:0] mask, input int n);
    req = mask; we = '0; addr = 6'($urandom);
    acks.delete(); gcyc.delete();
    for (int c = 0; c < 3 * n + 9 && acks.size() < n; c++) begin
      @(negedge clk);
      if (ack != 2'b00) begin acks.push_back(ack); gcyc.push_back(c); end
      step();
    end
    req = '0;
  endtask

  task automatic check_grants(input string nm, input logic [1:0] mask, input int n);
    logic [1:0] e;
    n_checks++;
    if (acks.size() != n) $display("FAIL %s_count got %0d want %0d", nm, acks.size(), n); else n_pass++;
    for (int j = 0; j < acks.size(); j++) begin
      e = 2'b01 << exp_win(mask);
      n_checks++;
      if (acks[j] !== e) $display("FAIL %s_grant%0d got %b want %b", nm, j, acks[j], e); else n_pass++;
      if (j > 0) begin
        n_checks++;
        if (gcyc[j] - gcyc[j-1] != 3) $display("FAIL %s_gap%0d got %0d want 3", nm, j, gcyc[j] - gcyc[j-1]);
        else n_pass++;
      end
      mptr = next_ptr(exp_win(mask));
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 5;
    if (ack !== 2'b00) $display("FAIL rst_ack got %b want 00", ack); else n_pass++;
    if (rdata !== 16'h0) $display("FAIL rst_rdata got %h want 0", rdata); else n_pass++;
    if (ram_load !== 1'b0) $display("FAIL rst_load got %b want 0", ram_load); else n_pass++;
    if (ram_address !== 3'd0) $display("FAIL rst_addr got %0d want 0", ram_address); else n_pass++;
    if (ram_in !== 16'h0) $display("FAIL rst_in got %h want 0", ram_in); else n_pass++;
    tb_init = 1'b0; reset = 1'b0; mptr = 0;
    step();
  endtask

  task automatic test_reset_access();
    int lc = load_count;
    req[0] = 1'b1; we[0] = 1'b1; addr[2:0] = 3'd2; wdata[15:0] = ~model_mem[2];
    step();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ram_load !== 1'b0) $display("FAIL rstacc_load_gate got %b want 0", ram_load); else n_pass++;
    repeat (2) step();
    req = '0; we = '0;
    @(negedge clk);
    n_checks += 7;
    if (ack !== 2'b00) $display("FAIL rstacc_ack got %b want 00", ack); else n_pass++;
    if (ram_load !== 1'b0) $display("FAIL rstacc_load got %b want 0", ram_load); else n_pass++;
    if (ram_address !== 3'd0) $display("FAIL rstacc_addr got %0d want 0", ram_address); else n_pass++;
    if (ram_in !== 16'h0) $display("FAIL rstacc_in got %h want 0", ram_in); else n_pass++;
    if (rdata !== 16'h0) $display("FAIL rstacc_rdata got %h want 0", rdata); else n_pass++;
    if (load_count != lc) $display("FAIL rstacc_writes got %0d want %0d", load_count, lc); else n_pass++;
    if (bank_mem[2] !== model_mem[2]) $display("FAIL rstacc_bank got %h want %h", bank_mem[2], model_mem[2]); else n_pass++;
    reset = 1'b0; mptr = 0;
    step();
    run_grants(2'b11, 1);
    check_grants("rstacc_next", 2'b11, 1);
  endtask

  task automatic test_single_write();
    int lat, lcyc, lc;
    logic [15:0] rd, old;
    logic [1:0] av;
    old = model_mem[5]; lc = load_count;
    access(0, 1'b1, 3'd5, 16'hBEEF, lat, lcyc, rd, av);
    model_mem[5] = 16'hBEEF;
    n_checks += 5;
    if (lat != 3) $display("FAIL wr_latency got %0d want 3", lat); else n_pass++;
    if (av !== 2'b01) $display("FAIL wr_ack got %b want 01", av); else n_pass++;
    if (lcyc != 2) $display("FAIL wr_load_cycle got %0d want 2", lcyc); else n_pass++;
    if (load_count - lc != 1) $display("FAIL wr_load_count got %0d want 1", load_count - lc); else n_pass++;
    if (rd !== old) $display("FAIL wr_rdata got %h want %h", rd, old); else n_pass++;
    access(0, 1'b0, 3'd5, 16'h0, lat, lcyc, rd, av);
    n_checks += 2;
    if (rd !== 16'hBEEF) $display("FAIL rd_back got %h want beef", rd); else n_pass++;
    if (lcyc != -1) $display("FAIL rd_load got %0d want -1", lcyc); else n_pass++;
  endtask

  task automatic test_write_read();
    int lat, lcyc, i;
    logic [15:0] rd, old, d;
    logic [1:0] av;
    logic [2:0] a;
    i = $urandom_range(1, 0); a = 3'($urandom); old = model_mem[a]; d = ~old;
    access(i, 1'b1, a, d, lat, lcyc, rd, av);
    model_mem[a] = d;
    n_checks++;
    if (rd !== old) $display("FAIL wrrd_old got %h want %h", rd, old); else n_pass++;
    access(1 - i, 1'b0, a, 16'h0, lat, lcyc, rd, av);
    n_checks++;
    if (rd !== d) $display("FAIL wrrd_new got %h want %h", rd, d); else n_pass++;
  endtask

  task automatic test_late_arrival();
    int c0 = -1, c1 = -1;
    logic a0, a1;
    req[0] = 1'b1; we[0] = 1'b0; addr[2:0] = 3'($urandom);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      a0 = ack[0]; a1 = ack[1];
      if (a0) c0 = c;
      if (a1) c1 = c;
      step();
      if (c == 0) begin req[1] = 1'b1; we[1] = 1'b0; addr[5:3] = 3'($urandom); end
      if (a0) req[0] = 1'b0;
      if (a1) req[1] = 1'b0;
    end
    req = '0;
    mptr = 0;
    n_checks += 2;
    if (c0 != 2) $display("FAIL late_ack0_cycle got %0d want 2", c0); else n_pass++;
    if (c1 != 5) $display("FAIL late_ack1_cycle got %0d want 5", c1); else n_pass++;
  endtask

  task automatic test_contention();
    run_grants(2'b11, 4);
    check_grants("contend", 2'b11, 4);
    n_checks++;
    if (gcyc.size() < 1 || gcyc[0] != 2) $display("FAIL contend_first got %0d want 2", gcyc.size() ? gcyc[0] : -1);
    else n_pass++;
  endtask

  task automatic test_reset_resp();
    bit seen = 1'b0;
    req[0] = 1'b1; we[0] = 1'b0; addr[2:0] = 3'($urandom);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (ack != 2'b00) begin seen = 1'b1; reset = 1'b1; end
      step();
    end
    req = '0;
    @(negedge clk);
    n_checks += 2;
    if (!seen) $display("FAIL rstresp_ack_seen got 0 want 1"); else n_pass++;
    if (ack !== 2'b00) $display("FAIL rstresp_ack_drop got %b want 00", ack); else n_pass++;
    reset = 1'b0; mptr = 0;
    step();
  endtask

  task automatic test_lock();
    lock = 2'b01;
    run_grants(2'b11, 3);
    check_grants("lock_on", 2'b11, 3);
    lock = 2'b00;
    run_grants(2'b11, 1);
    check_grants("lock_off", 2'b11, 1);
  endtask

  task automatic test_back_to_back();
    int lat, lcyc, i, exp_l;
    bit w;
    logic [15:0] rd, d, e;
    logic [1:0] av, m;
    logic [2:0] a;
    for (int n = 0; n < 12; n++) begin
      i = $urandom_range(1, 0); w = 1'($urandom); a = 3'($urandom); d = 16'($urandom);
      e = model_mem[a];
      access(i, w, a, d, lat, lcyc, rd, av);
      if (w) model_mem[a] = d;
      exp_l = w ? 2 : -1;
      n_checks += 4;
      if (lat != 3) $display("FAIL rnd%0d_latency got %0d want 3", n, lat); else n_pass++;
      if (av !== 2'b01 << i) $display("FAIL rnd%0d_ack got %b want %b", n, av, 2'b01 << i); else n_pass++;
      if (rd !== e) $display("FAIL rnd%0d_rdata got %h want %h", n, rd, e); else n_pass++;
      if (lcyc != exp_l) $display("FAIL rnd%0d_load got %0d want %0d", n, lcyc, exp_l); else n_pass++;
    end
    for (int n = 0; n < 4; n++) begin
      m = 2'($urandom_range(3, 1));
      run_grants(m, 2);
      check_grants("rnd_mask", m, 2);
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      init_val[k] = 16'($urandom);
      model_mem[k] = init_val[k];
    end
    test_reset();
    test_reset_access();
    test_single_write();
    test_write_read();
    test_late_arrival();
    test_contention();
    test_reset_resp();
    test_lock();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
